// File: rtl/seq_alu_pkg.sv
// Shared types for seq_alu: opcodes, FSM states and the legal-opcode table.
// POW is only legal when SEQ_ALU_POW_EN is defined.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_MOD = 3'b100,
    OP_POW = 3'b101
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

`ifdef SEQ_ALU_POW_EN
  localparam int NUM_LEGAL_OPS = 6;
  localparam opcode_e LEGAL_OPS [NUM_LEGAL_OPS] =
    '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_POW};
`else
  localparam int NUM_LEGAL_OPS = 5;
  localparam opcode_e LEGAL_OPS [NUM_LEGAL_OPS] =
    '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD};
`endif

  function automatic logic is_legal_op(input logic [2:0] s);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_LEGAL_OPS; i++) begin
      if (s == LEGAL_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/seq_alu_div.sv
// Iterative restoring divider: start loads the dividend, each step retires one
// quotient bit MSB first; after WIDTH steps quotient/remainder are final.
module seq_alu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   trial;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

  // A borrow in the top bit of trial means the divisor did not fit: restore.
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, divisor};
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: ADD/SUB/MUL in one cycle, DIV/MOD/POW iterative.
// Define SEQ_ALU_POW_EN to build the POW engine; otherwise sel=101 is illegal.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic             err_q, err_d;

  logic             accept, is_iter, div_zero, div_start, div_step;
  logic [WIDTH-1:0] single_res;
  logic             single_err;
  logic [WIDTH-1:0] quo, rem;
  logic [WIDTH-1:0] mul_x, mul_y, mul_p;

`ifdef SEQ_ALU_POW_EN
  logic [WIDTH-1:0] acc_q, acc_d, base_q, base_d, sq_p;
`endif

  seq_alu_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .step      (div_step),
    .dividend  (a),
    .divisor   (b_q),
    .quotient  (quo),
    .remainder (rem)
  );

  // One multiplier serves MUL in IDLE and the POW accumulate step in BUSY.
`ifdef SEQ_ALU_POW_EN
  assign mul_x = (state_q == BUSY) ? acc_q  : a;
  assign mul_y = (state_q == BUSY) ? base_q : b;
  assign sq_p  = base_q * base_q;
`else
  assign mul_x = a;
  assign mul_y = b;
`endif
  assign mul_p = mul_x * mul_y;

  assign accept   = in_valid && (state_q == IDLE);
  assign div_zero = (b == '0) && ((sel == OP_DIV) || (sel == OP_MOD));
  assign is_iter  = is_legal_op(sel) && !div_zero &&
                    ((sel == OP_DIV) || (sel == OP_MOD) || (sel == OP_POW));

  always_comb begin
    single_res = '0;
    single_err = 1'b0;
    case (sel)
      OP_ADD:  single_res = a + b;
      OP_SUB:  single_res = a - b;
      OP_MUL:  single_res = mul_p;
      OP_DIV:  begin single_res = '1; single_err = 1'b1; end
      OP_MOD:  begin single_res = a;  single_err = 1'b1; end
      default: begin single_res = '0; single_err = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      b_q     <= '0;
      op_q    <= '0;
      imm_q   <= '0;
      err_q   <= 1'b0;
`ifdef SEQ_ALU_POW_EN
      acc_q   <= '0;
      base_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      err_q   <= err_d;
`ifdef SEQ_ALU_POW_EN
      acc_q   <= acc_d;
      base_q  <= base_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    b_d       = b_q;
    op_d      = op_q;
    imm_d     = imm_q;
    err_d     = err_q;
    div_start = 1'b0;
    div_step  = 1'b0;
`ifdef SEQ_ALU_POW_EN
    acc_d     = acc_q;
    base_d    = base_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          b_d  = b;
          op_d = sel;
          if (is_iter) begin
            state_d   = BUSY;
            cnt_d     = '0;
            err_d     = 1'b0;
            div_start = (sel == OP_DIV) || (sel == OP_MOD);
`ifdef SEQ_ALU_POW_EN
            acc_d     = WIDTH'(1);
            base_d    = a;
`endif
          end else begin
            state_d = DONE;
            imm_d   = single_res;
            err_d   = single_err;
          end
        end
      end
      BUSY: begin
        cnt_d    = cnt_q + 1'b1;
        div_step = (op_q == OP_DIV) || (op_q == OP_MOD);
`ifdef SEQ_ALU_POW_EN
        if (op_q == OP_POW) begin
          if (b_q[cnt_q]) acc_d = mul_p;
          base_d = sq_p;
        end
`endif
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Error results and single-cycle ops come from imm_q; iterative ones from their engines.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    err       = (state_q == DONE) && err_q;
    y         = '0;
    if (state_q == DONE) begin
      if (err_q) begin
        y = imm_q;
      end else begin
        case (op_q)
          OP_DIV:  y = quo;
          OP_MOD:  y = rem;
`ifdef SEQ_ALU_POW_EN
          OP_POW:  y = acc_q;
`endif
          default: y = imm_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32.
module tb_seq_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [2:0]  sel_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        err;

  int compared;
  int mismatched;

  seq_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .sel       (sel_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] ts);
    a_in     = ta;
    b_in     = tb;
    sel_in   = ts;
    in_valid = 1'b1;
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                       input logic [2:0] ts, input logic [31:0] ey, input logic ee,
                       input int el);
    int   lat;
    logic rdy_low;
    applyStimulus(ta, tb, ts);
    lat     = 1;
    rdy_low = 1'b1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_lat"}, 32'(lat), 32'(el));
    checkOutput({tag, "_y"}, y, ey);
    checkOutput({tag, "_err"}, 32'(err), 32'(ee));
    if (el > 1) checkOutput({tag, "_busy_ready_low"}, 32'(rdy_low), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    a_in       = '0;
    b_in       = '0;
    sel_in     = '0;
    out_ready  = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_y", y, 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] single-cycle ops");
    runOp("add", 32'd10, 32'd2, 3'b000, 32'd12, 1'b0, 1);
    runOp("sub", 32'd2, 32'd10, 3'b001, 32'hFFFF_FFF8, 1'b0, 1);
    runOp("mul", 32'h0001_0003, 32'h0001_0002, 3'b010, 32'h0005_0006, 1'b0, 1);

    $display("[TB] iterative ops");
    runOp("div", 32'd100, 32'd7, 3'b011, 32'd14, 1'b0, 33);
    runOp("mod", 32'd100, 32'd7, 3'b100, 32'd2, 1'b0, 33);
    runOp("div_big", 32'hFFFF_FFFF, 32'd16, 3'b011, 32'h0FFF_FFFF, 1'b0, 33);
`ifdef SEQ_ALU_POW_EN
    runOp("pow_3_5", 32'd3, 32'd5, 3'b101, 32'd243, 1'b0, 33);
    runOp("pow_2_40", 32'd2, 32'd40, 3'b101, 32'd0, 1'b0, 33);
    runOp("pow_0_0", 32'd0, 32'd0, 3'b101, 32'd1, 1'b0, 33);
`else
    runOp("pow_disabled", 32'd3, 32'd5, 3'b101, 32'd0, 1'b1, 1);
`endif

    $display("[TB] error paths");
    runOp("div_by_zero", 32'd10, 32'd0, 3'b011, 32'hFFFF_FFFF, 1'b1, 1);
    runOp("mod_by_zero", 32'd10, 32'd0, 3'b100, 32'd10, 1'b1, 1);
    runOp("illegal_110", 32'd7, 32'd9, 3'b110, 32'd0, 1'b1, 1);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(32'd5, 32'd6, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_y", y, 32'd11);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      a_in     = 32'd40;
      b_in     = 32'd2;
      sel_in   = 3'b000;
      in_valid = (i % 2 == 0);
    end
    a_in      = 32'd1;
    b_in      = 32'd2;
    sel_in    = 3'b000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_after_hs_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_after_hs_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_next_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_next_y", y, 32'd3);
    @(negedge clk);

    $display("[TB] reset abort");
    applyStimulus(32'd1000, 32'd3, 3'b011);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_y", y, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    runOp("add_after_reset", 32'd1, 32'd1, 3'b000, 32'd2, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
